// File: rtl/fifo_rd_pkg.sv
// Shared sizing helpers for the async-FIFO read-side stream adapter.
// Statistics width is fixed here so the optional counters and their users agree.
package fifo_rd_pkg;

  localparam int STAT_W = 32;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int cnt_w(input int burst_len);
    return (burst_len > 0) ? $clog2(burst_len + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular prefetch buffer sitting between the FIFO read port and the stream output.
// Push/pop/flush with occupancy; the head entry is presented combinationally.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic [occ_w(DEPTH)-1:0]   occ
);

  localparam int PW = ptr_w(DEPTH);
  localparam int OW = occ_w(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic                  do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop && (occ != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !do_pop) begin
        occ <= occ + 1'b1;
      end else if (!push && do_pop) begin
        occ <= occ - 1'b1;
      end
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst || flush)
    !(push && !do_pop && (occ == FULL_OCC)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: FIFO read port -> valid/ready stream with burst framing (m_last).
// Optional saturating statistics counters are enabled with FIFO_RD_STREAM_STAT_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 3,
  parameter int BURST_LEN  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_ren,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_RD_STREAM_STAT_EN
  ,
  output logic [STAT_W-1:0]     stat_words,
  output logic [STAT_W-1:0]     stat_stall
`endif
);

  localparam int OW = occ_w(BUF_DEPTH);
  localparam int CW = cnt_w(BURST_LEN);

  typedef logic [CW-1:0] burst_cnt_t;
  localparam burst_cnt_t CNT_LAST = burst_cnt_t'(BURST_LEN - 1);

  logic [OW-1:0] occ;
  logic          inflight;
  logic          accept;
  logic          push;
  logic          pop;
  burst_cnt_t    cnt;

  // Counting in-flight words against the buffer makes overflow impossible under backpressure.
  assign fifo_ren = !fifo_empty && !flush && !rd_rst &&
                    ((int'(occ) + int'(inflight)) < BUF_DEPTH);

  assign m_valid = (occ != '0);
  assign m_last  = m_valid && (cnt == CNT_LAST);
  assign accept  = m_valid && m_ready;
  assign pop     = accept && !flush;
  assign push    = inflight && !flush;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_dout),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  always_ff @(posedge rd_clk) begin
    if (rd_rst || flush) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_ren && !fifo_empty;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst || flush) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

`ifdef FIFO_RD_STREAM_STAT_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  always_ff @(posedge rd_clk) begin
    if (rd_rst || flush) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && (stat_words != STAT_MAX)) begin
        stat_words <= stat_words + 1'b1;
      end
      if (m_valid && !m_ready && (stat_stall != STAT_MAX)) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO model feeding a data scoreboard plus cycle checks.
// Stat counters are checked only when FIFO_RD_STREAM_STAT_EN is defined.
module tb_fifo_rd_stream;

  localparam int DW = 32;
  localparam int BL = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          flush;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_ren;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [31:0]   stat_words;
  logic [31:0]   stat_stall;
`endif

  int total = 0;
  int bad   = 0;
  int beat  = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic rdy;
    logic ren;
    logic vld;
    logic dchk;
  } vec_t;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(3), .BURST_LEN(BL)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  // FIFO read port model: registered dout, empty flag updated at the clock edge.
  always @(posedge rd_clk) begin
    if (fifo_ren) fifo_dout <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge rd_clk) begin
    if (!rd_rst && !flush && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got data %0h, want no beat", m_data);
      end else begin
        chk("pop_data", m_data, exp_q.pop_front());
        chk("pop_last", m_last, (beat % BL) == (BL - 1));
        beat++;
      end
    end
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
  endtask

  task automatic drain(input string nm, input int lim, input logic tog);
    int n = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < lim) begin
      step();
      if (tog) m_ready = ~m_ready;
      n++;
    end
    @(negedge rd_clk);
    chk(nm, exp_q.size(), 0);
    chk({nm, "_idle"}, m_valid, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[20];
    for (int i = 0; i < 20; i++) begin
      tbl[i].rdy  = 1'b0;
      tbl[i].ren  = (i < 3);
      tbl[i].vld  = (i >= 2);
      tbl[i].dchk = (i >= 2);
    end

    rd_rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    step(); step();
    @(negedge rd_clk);
    chk("rst_ren", fifo_ren, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_last", m_last, 1'b0);
    step();
    rd_rst = 1'b0;

    // Streaming at full rate: 40 words, last on beats 15 and 31
    m_ready = 1'b1;
    load(32'h100, 40);
    step();
    for (int i = 0; i < 43; i++) begin
      @(negedge rd_clk);
      chk("t1_ren", fifo_ren, (i < 40));
      chk("t1_valid", m_valid, (i >= 2) && (i < 42));
      step();
    end
    chk("t1_left", exp_q.size(), 0);

    // Backpressure: three reads then hold the head word
    m_ready = 1'b0;
    load(32'h200, 10);
    step();
    for (int i = 0; i < 20; i++) begin
      m_ready = tbl[i].rdy;
      @(negedge rd_clk);
      chk("t2_ren", fifo_ren, tbl[i].ren);
      chk("t2_valid", m_valid, tbl[i].vld);
      if (tbl[i].dchk) chk("t2_hold", m_data, 32'h200);
      step();
    end
    drain("t2_drain", 100, 1'b0);
`ifdef FIFO_RD_STREAM_STAT_EN
    chk("t2_stat_words", stat_words, 50);
    chk("t2_stat_stall", stat_stall, 18);
`endif

    // Flush with an empty buffer restarts the burst; ren is blocked in the flush cycle
    load(32'h300, 32);
    step();
    flush = 1'b1;
    beat = 0;
    @(negedge rd_clk);
    chk("t3_flush_ren", fifo_ren, 1'b0);
    step();
    flush = 1'b0;
    @(negedge rd_clk);
    chk("t3_ren", fifo_ren, 1'b1);
    chk("t3_valid", m_valid, 1'b0);
    step();
    drain("t3_drain", 300, 1'b1);

    // Flush with occ=2 and one word in flight: three words are lost
    m_ready = 1'b0;
    load(32'h400, 20);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge rd_clk);
      chk("t4_ren", fifo_ren, 1'b1);
      step();
    end
    flush = 1'b1;
    beat = 0;
    @(negedge rd_clk);
    chk("t4_flush_ren", fifo_ren, 1'b0);
    chk("t4_valid_pre", m_valid, 1'b1);
    step();
    flush = 1'b0;
    repeat (3) void'(exp_q.pop_front());
    @(negedge rd_clk);
    chk("t4_valid_post", m_valid, 1'b0);
    chk("t4_ren_post", fifo_ren, 1'b1);
    step();
    drain("t4_drain", 200, 1'b0);

    // Reset mid-burst together with flush
    m_ready = 1'b1;
    load(32'h500, 20);
    step();
    repeat (6) step();
    rd_rst = 1'b1;
    flush = 1'b1;
    @(negedge rd_clk);
    chk("t5_ren_rst", fifo_ren, 1'b0);
    step();
    fifo_q.delete();
    exp_q.delete();
    beat = 0;
    @(negedge rd_clk);
    chk("t5_valid", m_valid, 1'b0);
    chk("t5_data", m_data, 32'h0);
    chk("t5_last", m_last, 1'b0);
    chk("t5_ren", fifo_ren, 1'b0);
`ifdef FIFO_RD_STREAM_STAT_EN
    chk("t5_stat_words0", stat_words, 0);
    chk("t5_stat_stall0", stat_stall, 0);
`endif
    step();
    rd_rst = 1'b0;
    flush = 1'b0;

    m_ready = 1'b0;
    load(32'h600, 5);
    step();
    repeat (22) step();
    drain("t5_drain", 100, 1'b0);
`ifdef FIFO_RD_STREAM_STAT_EN
    chk("t5_stat_stall", stat_stall, 20);
    chk("t5_stat_words", stat_words, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
